instr_decode_stage: RTL



---
 rtl/instr_decode_stage_if.sv | 35 +++
 rtl/instr_decode_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/instr_decode_stage_if.sv
// Handshake and decoded-bundle bus for the instruction decode stage.
// The stage uses the slave view; whoever feeds and drains it uses master.
interface instr_decode_stage_if #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         alu_op;
    logic [REG_AW-1:0]  addr1;
    logic [REG_AW-1:0]  addr2;
    logic [DATA_W-1:0]  imm;
    logic               use_imm;
    logic               write;
    logic               show;
    logic               illegal;
    logic [CNT_W-1:0]   illegal_cnt;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_op, addr1, addr2, imm,
        input  use_imm, write, show, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alu_op, addr1, addr2, imm,
        output use_imm, write, show, illegal, illegal_cnt
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered R/I-type instruction decoder with a 2-entry skid buffer,
// synchronous flush and a saturating illegal-instruction counter.
module instr_decode_stage #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic rst_n,
    input logic flush,
    instr_decode_stage_if.slave bus
);
    localparam int FUNC_W = INSTR_W - 1 - 2 * REG_AW;
    localparam int IMM_W  = INSTR_W - 4 - REG_AW;

    typedef struct packed {
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] addr1;
        logic [REG_AW-1:0] addr2;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic              write;
        logic              show;
        logic              illegal;
    } bundle_t;

    bundle_t            dec;
    bundle_t            m_q;
    bundle_t            s_q;
    logic               m_full;
    logic               s_full;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_i;
    logic [FUNC_W-1:0]  func;
    logic [2:0]         op;
    logic               accept;
    logic               xfer;

    assign is_i = bus.instr[INSTR_W-1];
    assign func = bus.instr[INSTR_W-2:2*REG_AW];
    assign op   = bus.instr[INSTR_W-2:INSTR_W-4];

    always_comb begin
        dec = '0;
        if (is_i) begin
            dec.addr1 = bus.instr[INSTR_W-5 -: REG_AW];
            dec.imm   = DATA_W'($signed(bus.instr[IMM_W-1:0]));
        end else begin
            dec.addr1 = bus.instr[2*REG_AW-1:REG_AW];
            dec.addr2 = bus.instr[REG_AW-1:0];
        end
        unique case (1'b1)
            is_i && op == 3'b000: begin
                dec.alu_op  = 4'b0001;
                dec.use_imm = 1'b1;
                dec.write   = 1'b1;
            end
            is_i && op == 3'b001: begin
                dec.alu_op  = 4'b1110;
                dec.use_imm = 1'b1;
                dec.write   = 1'b1;
            end
            !is_i && func == FUNC_W'(0): begin
                dec.alu_op = 4'b0000;
            end
            !is_i && func >= FUNC_W'(1) && func <= FUNC_W'(5): begin
                dec.alu_op = 4'(func);
                dec.write  = 1'b1;
            end
            !is_i && func == FUNC_W'(18): begin
                dec.alu_op = 4'b1111;
                dec.show   = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign accept = bus.in_valid & ~s_full;
    assign xfer   = m_full & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0;
            s_full <= 1'b0;
            m_q    <= '0;
            s_q    <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            m_full <= 1'b0;
            s_full <= 1'b0;
        end else begin
            if (xfer) begin
                if (s_full) begin
                    m_q <= s_q;
                    if (accept) begin
                        s_q <= dec;
                    end else begin
                        s_full <= 1'b0;
                    end
                end else if (accept) begin
                    m_q <= dec;
                end else begin
                    m_full <= 1'b0;
                end
            end else if (accept) begin
                if (!m_full) begin
                    m_q    <= dec;
                    m_full <= 1'b1;
                end else begin
                    s_q    <= dec;
                    s_full <= 1'b1;
                end
            end
            if (accept && dec.illegal && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // in_ready comes straight from the skid flag, so it is registered.
    assign bus.in_ready    = ~s_full;
    assign bus.out_valid   = m_full;
    assign bus.alu_op      = m_q.alu_op;
    assign bus.addr1       = m_q.addr1;
    assign bus.addr2       = m_q.addr2;
    assign bus.imm         = m_q.imm;
    assign bus.use_imm     = m_q.use_imm;
    assign bus.write       = m_q.write;
    assign bus.show        = m_q.show;
    assign bus.illegal     = m_q.illegal;
    assign bus.illegal_cnt = cnt_q;
endmodule
